// File: rtl/store_pack_buf_pkg.sv
// Shared constants for the store packing buffer: store opcodes, lane masks
// and the width of one queued store entry.
package store_pack_buf_pkg;

    localparam logic [1:0] ST_SW  = 2'd0;
    localparam logic [1:0] ST_SH  = 2'd1;
    localparam logic [1:0] ST_SB  = 2'd2;
    localparam logic [1:0] ST_RSV = 2'd3;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam logic [3:0] BE_HALF = 4'h3;
    localparam logic [3:0] BE_BYTE = 4'h1;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    // One entry holds {word address, byte enables, lane-aligned data}.
    function automatic int entry_width(input int aw);
        return aw + BE_W + DATA_W;
    endfunction

endpackage

// File: rtl/store_pack_buf_st_lane_pack.sv
// Combinational store packer: turns an op, the low address bits and the
// register value into byte enables, replicated lane data and a legality flag.
module st_lane_pack
    import store_pack_buf_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        legal
);

    // Select lane mask and replication pattern; misaligned or reserved ops are illegal.
    always_comb begin
        be    = 4'b0000;
        wdata = data;
        legal = 1'b0;
        case (op)
            ST_SW: begin
                be    = BE_WORD;
                wdata = data;
                legal = (addr == 2'b00);
            end
            ST_SH: begin
                be    = BE_HALF << addr;
                wdata = {2{data[15:0]}};
                legal = !addr[0];
            end
            ST_SB: begin
                be    = BE_BYTE << addr;
                wdata = {4{data[7:0]}};
                legal = 1'b1;
            end
            default: begin
                be    = 4'b0000;
                wdata = data;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_pack_buf.sv
// Store packing buffer: packs MEM-stage stores into byte-enable form and
// queues them in a small FIFO in front of the data memory write port.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on registered occupancy (never on mem_ready), and
// mem_valid/mem_* come only from the head entry register, so neither side has a
// combinational path through the buffer. Illegal requests are consumed (not
// queued) and reported with a one-cycle misalign pulse.
module store_pack_buf
    import store_pack_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_data,
    input  logic [1:0]    in_op,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    output logic          misalign,
    output logic          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EW    = entry_width(AW);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [EW-1:0]    entry_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic [3:0]  pack_be;
    logic [31:0] pack_wdata;
    logic        pack_legal;
    logic        req_take;
    logic        push;
    logic        pop;
    logic [EW-1:0] head;

    st_lane_pack u_pack (
        .op    (in_op),
        .addr  (in_addr[1:0]),
        .data  (in_data),
        .be    (pack_be),
        .wdata (pack_wdata),
        .legal (pack_legal)
    );

    assign in_ready  = (count != CNT_FULL);
    assign empty     = (count == '0);
    assign mem_valid = !empty;

    assign req_take = in_valid && in_ready;
    assign push     = req_take && pack_legal;
    assign pop      = mem_valid && mem_ready;

    // Storage is not reset, so the head is masked to zero while the queue is empty.
    assign head      = entry_mem[rd_ptr];
    assign mem_addr  = mem_valid ? head[EW-1 -: AW] : '0;
    assign mem_be    = mem_valid ? head[DATA_W +: BE_W] : '0;
    assign mem_wdata = mem_valid ? head[DATA_W-1:0] : '0;

    // Write the packed, word-aligned entry into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr] <= {in_addr[AW-1:2], 2'b00, pack_be, pack_wdata};
        end
    end

    // Pointers, occupancy and the misalign pulse; reset drops every queued entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            misalign <= req_take && !pack_legal;
        end
    end

endmodule

// File: tb/tb_store_pack_buf.sv
// Self-checking bench for store_pack_buf with a queue-based reference model.
module tb_store_pack_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_op;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        misalign;
    logic        empty;

    logic [67:0] exp_q[$];
    logic        exp_mis;
    int          vectors;
    int          miscompares;

    store_pack_buf #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_op     (in_op),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .misalign  (misalign),
        .empty     (empty)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected entry from the store rules: access size in bytes decides
    // alignment, a contiguous lane mask shifted to the byte offset, and the
    // accessed bytes copied into every lane.
    function automatic logic [67:0] model_entry(input logic [1:0] op, input logic [31:0] addr,
                                                input logic [31:0] data, output logic legal);
        int nbytes;
        int ofs;
        logic [3:0]  be;
        logic [31:0] wd;
        ofs = int'(addr % 32'd4);
        case (op)
            2'd0:    nbytes = 4;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 1;
            default: nbytes = 0;
        endcase
        legal = (nbytes != 0) && ((ofs % ((nbytes == 0) ? 1 : nbytes)) == 0);
        be = 4'(((1 << nbytes) - 1) << ofs);
        if (nbytes == 4)      wd = data;
        else if (nbytes == 2) wd = (data % 32'h10000) * 32'h00010001;
        else                  wd = (data % 32'h100) * 32'h01010101;
        return {addr - (addr % 32'd4), be, wd};
    endfunction

    // Driver: present one cycle of inputs, advance the model at the edge,
    // leave time 1 unit after the edge so outputs can be sampled.
    task automatic apply(input logic v, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic mr);
        logic        legal;
        logic        rdy;
        logic [67:0] e;
        in_valid  = v;
        in_op     = op;
        in_addr   = addr;
        in_data   = data;
        mem_ready = mr;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_mis = 1'b0;
        end else begin
            rdy = (exp_q.size() < DEPTH);
            e = model_entry(op, addr, data, legal);
            if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
            if (v && rdy && legal) exp_q.push_back(e);
            exp_mis = v && rdy && !legal;
        end
        #1;
    endtask

    task automatic idle(input logic mr);
        apply(1'b0, 2'd0, 32'h0, 32'h0, mr);
    endtask

    function automatic logic [31:0] legal_addr(input logic [1:0] op);
        logic [31:0] base;
        base = $urandom & 32'h0000_0FFC;
        if (op == 2'd1)      return base + 32'(2 * $urandom_range(0, 1));
        else if (op == 2'd2) return base + 32'($urandom_range(0, 3));
        else                 return base;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            vectors++;
            if ({in_ready, empty, mem_valid, misalign} !== 4'b1100) begin
                miscompares++;
                $display("FAIL reset_flags cyc %0d: rdy/empty/valid/mis=%b expected 1100", i,
                         {in_ready, empty, mem_valid, misalign});
            end
            vectors++;
            if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin
                miscompares++;
                $display("FAIL reset_mem cyc %0d: got %h expected 0", i, {mem_addr, mem_be, mem_wdata});
            end
        end
    endtask

    task automatic test_sb();
        apply(1'b1, 2'd2, 32'h0000_0013, 32'h1234_56AB, 1'b1);
        vectors++;
        if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h0000_0010, 4'b1000, 32'hABAB_ABAB}) begin
            miscompares++;
            $display("FAIL sb_head: valid=%b addr=%h be=%b wdata=%h expected 1 00000010 1000 abababab",
                     mem_valid, mem_addr, mem_be, mem_wdata);
        end
        idle(1'b1);
        vectors++;
        if (empty !== 1'b1 || mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_drain: empty=%b valid=%b expected 1 0", empty, mem_valid);
        end
    endtask

    task automatic test_fill();
        logic [31:0] d1;
        logic [31:0] d2;
        d1 = $urandom;
        d2 = $urandom;
        apply(1'b1, 2'd1, 32'h0000_0102, d1, 1'b0);
        apply(1'b1, 2'd0, 32'h0000_0104, d2, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: in_ready=%b empty=%b expected 0 0", in_ready, empty);
        end
        apply(1'b1, 2'd2, 32'h0000_0108, $urandom, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_block: in_ready=%b misalign=%b expected 0 0", in_ready, misalign);
        end
        vectors++;
        if ({mem_addr, mem_be, mem_wdata} !== {32'h0000_0100, 4'b1100, d1[15:0], d1[15:0]}) begin
            miscompares++;
            $display("FAIL fill_head0: got %h %b %h expected 00000100 1100 %h",
                     mem_addr, mem_be, mem_wdata, {d1[15:0], d1[15:0]});
        end
        idle(1'b1);
        vectors++;
        if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h0000_0104, 4'hF, d2}) begin
            miscompares++;
            $display("FAIL fill_head1: got %b %h %b %h expected 1 00000104 1111 %h",
                     mem_valid, mem_addr, mem_be, mem_wdata, d2);
        end
        idle(1'b1);
        vectors++;
        if (empty !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drain: empty=%b in_ready=%b expected 1 1", empty, in_ready);
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  ops   [3];
        logic [31:0] addrs [3];
        ops[0] = 2'd0; addrs[0] = 32'h0000_0002;
        ops[1] = 2'd1; addrs[1] = 32'h0000_0001;
        ops[2] = 2'd3; addrs[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, ops[i], addrs[i], $urandom, 1'b1);
            vectors++;
            if (misalign !== 1'b1 || mem_valid !== 1'b0 || empty !== 1'b1) begin
                miscompares++;
                $display("FAIL mis_pulse op %0d: misalign=%b valid=%b empty=%b expected 1 0 1",
                         ops[i], misalign, mem_valid, empty);
            end
            idle(1'b1);
            vectors++;
            if (misalign !== 1'b0 || mem_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mis_clear op %0d: misalign=%b valid=%b expected 0 0",
                         ops[i], misalign, mem_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        op = 2'(($urandom_range(0, 2)));
        apply(1'b1, op, legal_addr(op), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) begin
            op = 2'(($urandom_range(0, 2)));
            apply(1'b1, op, legal_addr(op), $urandom, 1'b1);
            vectors++;
            if (mem_valid !== 1'b1 || in_ready !== 1'b1 || exp_q.size() != 1) begin
                miscompares++;
                $display("FAIL b2b_occ cyc %0d: valid=%b in_ready=%b model_size=%0d expected 1 1 1",
                         i, mem_valid, in_ready, exp_q.size());
            end
            vectors++;
            if (exp_q.size() == 0 || {mem_addr, mem_be, mem_wdata} !== exp_q[0]) begin
                miscompares++;
                $display("FAIL b2b_head cyc %0d: got %h expected %h", i,
                         {mem_addr, mem_be, mem_wdata}, (exp_q.size() != 0) ? exp_q[0] : 68'h0);
            end
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 2'd0, 32'h0000_0200, $urandom, 1'b0);
        apply(1'b1, 2'd2, 32'h0000_0205, $urandom, 1'b0);
        reset = 1'b1;
        idle(1'b1);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({mem_valid, empty, in_ready} !== 3'b011) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: valid/empty/rdy=%b expected 011", i,
                         {mem_valid, empty, in_ready});
            end
            idle(1'b1);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 300; i++) begin
            op = 2'(($urandom_range(0, 3)));
            apply(1'($urandom_range(0, 1)), op, $urandom & 32'h0000_0FFF, $urandom,
                  1'($urandom_range(0, 2) != 0));
            vectors++;
            if (mem_valid !== (exp_q.size() != 0) || empty !== (exp_q.size() == 0) ||
                in_ready !== (exp_q.size() < DEPTH) || misalign !== exp_mis) begin
                miscompares++;
                $display("FAIL rand_flags cyc %0d: valid=%b empty=%b rdy=%b mis=%b model_size=%0d model_mis=%b",
                         i, mem_valid, empty, in_ready, misalign, exp_q.size(), exp_mis);
            end
            vectors++;
            if ({mem_addr, mem_be, mem_wdata} !== ((exp_q.size() != 0) ? exp_q[0] : 68'h0)) begin
                miscompares++;
                $display("FAIL rand_head cyc %0d: got %h expected %h", i,
                         {mem_addr, mem_be, mem_wdata}, (exp_q.size() != 0) ? exp_q[0] : 68'h0);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_mis     = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_op       = 2'd0;
        in_addr     = 32'h0;
        in_data     = 32'h0;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sb();
        test_fill();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
